// File: rtl/modbus_rtu_frame_rx.sv
// Modbus RTU frame receiver: silence-delimited framing, byte buffer, CRC-16/MODBUS check.
// Optional device-address filtering is enabled with MODBUS_ADDR_FILTER_EN.
module modbus_rtu_frame_rx #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned MAX_LEN   = 256
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [7:0] rx_data,
    input  logic       rx_state,
    input  logic       rx_done,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_busy,
    output logic       frame_valid,
    output logic [8:0] frame_len,
    output logic       crc_ok,
    output logic       frame_err
`ifdef MODBUS_ADDR_FILTER_EN
    ,
    input  logic [7:0] dev_addr
`endif
);

    localparam int unsigned CHAR_CYC = (CLK_FREQ / BAUD_RATE) * 11;
    localparam int unsigned T15 = (BAUD_RATE <= 19200) ? (CHAR_CYC * 3 / 2)
                                                       : ((CLK_FREQ / 1000000) * 750);
    localparam int unsigned T35 = (BAUD_RATE <= 19200) ? (CHAR_CYC * 7 / 2)
                                                       : ((CLK_FREQ / 1000000) * 1750);
    localparam logic [23:0] T15_C = 24'(T15);
    localparam logic [23:0] T35_C = 24'(T35);
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [8:0] MAX_LEN_C = 9'(MAX_LEN);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_RECV,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [23:0] silence;
    logic        sil_full;
    logic        rx_state_q;
    logic        char_start;
    logic [8:0]  len;
    logic        err;
    logic [15:0] crc;
    logic        has_room;
    logic        wr_en;
    logic [AW-1:0] wr_addr;
    logic        addr_ok;
    logic        report;
    logic        crc_ok_nxt;
    logic [7:0]  buf_mem [MAX_LEN];

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int unsigned i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        end
        return r;
    endfunction

    assign sil_full = (silence == T35_C);
    assign has_room = (len < MAX_LEN_C);
    // Edge is taken against the previous level so the gap length is still visible in silence.
    assign char_start = rx_state & ~rx_state_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            silence    <= '0;
            rx_state_q <= 1'b0;
        end else begin
            rx_state_q <= rx_state;
            if (rx_state || rx_done) begin
                silence <= '0;
            end else if (!sil_full) begin
                silence <= silence + 24'd1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (sil_full) state_nxt = S_IDLE;
            S_IDLE:  if (rx_done) state_nxt = S_RECV;
            S_RECV:  if (!rx_done && sil_full) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    always_comb begin
        frame_busy = (state == S_RECV) || (state == S_DONE);
        report     = (state == S_DONE) && addr_ok;
        crc_ok_nxt = (crc == 16'h0000) && (len >= 9'd4) && !err;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            frame_valid <= 1'b0;
            frame_len   <= '0;
            crc_ok      <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= report;
            if (report) begin
                frame_len <= len;
                crc_ok    <= crc_ok_nxt;
                frame_err <= err;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            len <= '0;
            err <= 1'b0;
            crc <= 16'hFFFF;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rx_done) begin
                        len <= 9'd1;
                        err <= 1'b0;
                        crc <= crc16_byte(16'hFFFF, rx_data);
                    end
                end
                S_RECV: begin
                    if (rx_done) begin
                        if (has_room) begin
                            len <= len + 9'd1;
                            crc <= crc16_byte(crc, rx_data);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    if (char_start && (silence >= T15_C)) begin
                        err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MODBUS_ADDR_FILTER_EN
    logic [7:0] first_byte;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            first_byte <= '0;
        end else if ((state == S_IDLE) && rx_done) begin
            first_byte <= rx_data;
        end
    end

    assign addr_ok = (first_byte == dev_addr) || (first_byte == 8'h00);
`else
    assign addr_ok = 1'b1;
`endif

    assign wr_en   = rx_done && ((state == S_IDLE) || ((state == S_RECV) && has_room));
    assign wr_addr = (state == S_IDLE) ? '0 : len[AW-1:0];

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            buf_mem[wr_addr] <= rx_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < MAX_LEN_C) begin
            rd_data <= buf_mem[rd_addr[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_modbus_rtu_frame_rx.sv
// Scoreboard bench for modbus_rtu_frame_rx with scaled timing (T15=165, T35=385 cycles).
module tb_modbus_rtu_frame_rx;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic [7:0] rx_data;
    logic       rx_state;
    logic       rx_done;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_busy;
    logic       frame_valid;
    logic [8:0] frame_len;
    logic       crc_ok;
    logic       frame_err;

    always #5 clk_in = ~clk_in;

    modbus_rtu_frame_rx #(
        .CLK_FREQ (96000),
        .BAUD_RATE(9600),
        .MAX_LEN  (8)
    ) dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .rx_data    (rx_data),
        .rx_state   (rx_state),
        .rx_done    (rx_done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_busy (frame_busy),
        .frame_valid(frame_valid),
        .frame_len  (frame_len),
        .crc_ok     (crc_ok),
        .frame_err  (frame_err)
    );

    typedef struct packed {
        logic [8:0]  len;
        logic        ok;
        logic        err;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int unsigned total = 0;
    int unsigned bad   = 0;

    // Byte 0 sits in the least significant position.
    localparam logic [63:0] F_GOOD = {8'h0A, 8'h84, 8'h01, 8'h00, 8'h00, 8'h00, 8'h03, 8'h01};
    localparam logic [63:0] F_BADC = {8'h0B, 8'h84, 8'h01, 8'h00, 8'h00, 8'h00, 8'h03, 8'h01};
    localparam logic [63:0] F_ALT  = {8'h87, 8'h76, 8'h03, 8'h00, 8'h6B, 8'h00, 8'h03, 8'h11};
    localparam logic [79:0] F_LONG = {8'h55, 8'hAA, F_GOOD};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_in);
        rx_state = 1'b1;
        repeat (19) @(negedge clk_in);
        rx_state = 1'b0;
        rx_done  = 1'b1;
        rx_data  = b;
        @(negedge clk_in);
        rx_done  = 1'b0;
    endtask

    task automatic send_frame(input logic [79:0] fr, input int n, input int gap_idx, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i == gap_idx) idle(gap);
            send_byte(fr[8*i +: 8]);
        end
    endtask

    task automatic push_exp(input logic [8:0] len, input logic ok, input logic err,
                            input logic [63:0] data);
        exp_t e;
        e.len  = len;
        e.ok   = ok;
        e.err  = err;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per frame_valid and reads the buffer back.
    initial begin
        exp_t e;
        rd_addr = '0;
        forever begin
            @(negedge clk_in);
            if (frame_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_len", 32'(frame_len), 32'(e.len));
                    check("crc_ok", 32'(crc_ok), 32'(e.ok));
                    check("frame_err", 32'(frame_err), 32'(e.err));
                    for (int i = 0; (i < 8) && (i < int'(e.len)); i++) begin
                        rd_addr = 8'(i);
                        @(negedge clk_in);
                        check("rd_data", 32'(rd_data), 32'(e.data[8*i +: 8]));
                    end
                end
            end
        end
    end

    initial begin
        int waited;
        rst_n_in = 1'b0;
        rx_state = 1'b0;
        rx_done  = 1'b0;
        rx_data  = '0;
        idle(3);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_frame_len", 32'(frame_len), 32'd0);
        check("rst_crc_ok", 32'(crc_ok), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_frame_busy", 32'(frame_busy), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        rst_n_in = 1'b1;
        idle(400);

        push_exp(9'd8, 1'b1, 1'b0, F_GOOD);
        send_frame({16'h0, F_GOOD}, 8, -1, 0);
        check("busy_in_frame", 32'(frame_busy), 32'd1);
        idle(450);

        push_exp(9'd8, 1'b0, 1'b0, F_BADC);
        send_frame({16'h0, F_BADC}, 8, -1, 0);
        idle(450);
        check("held_frame_len", 32'(frame_len), 32'd8);
        check("held_crc_ok", 32'(crc_ok), 32'd0);
        check("idle_busy", 32'(frame_busy), 32'd0);

        push_exp(9'd8, 1'b0, 1'b1, F_GOOD);
        send_frame({16'h0, F_GOOD}, 8, 3, 250);
        idle(450);

        push_exp(9'd8, 1'b1, 1'b0, F_GOOD);
        send_frame({16'h0, F_GOOD}, 8, -1, 0);
        idle(500);
        push_exp(9'd8, 1'b1, 1'b0, F_ALT);
        send_frame({16'h0, F_ALT}, 8, -1, 0);
        idle(450);

        push_exp(9'd8, 1'b0, 1'b1, F_GOOD);
        send_frame(F_LONG, 10, -1, 0);
        idle(450);

        send_frame({16'h0, F_GOOD}, 3, -1, 0);
        rst_n_in = 1'b0;
        idle(2);
        check("midrst_busy", 32'(frame_busy), 32'd0);
        check("midrst_frame_len", 32'(frame_len), 32'd0);
        rst_n_in = 1'b1;
        send_frame({16'h0, F_GOOD}, 8, -1, 0);
        idle(450);
        push_exp(9'd8, 1'b1, 1'b0, F_ALT);
        send_frame({16'h0, F_ALT}, 8, -1, 0);
        idle(450);

        waited = 0;
        while ((exp_q.size() != 0) && (waited < 1000)) begin
            @(negedge clk_in);
            waited++;
        end
        check("pending_frames", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
